eater_core: RTL and testbench
=============================

# eater_core

Parametrised second-generation accumulator CPU core: a microcoded fetch/execute machine with A/B registers, adder/subtractor, carry/zero flags, conditional jumps, output register and internal RAM. It extends the 8-bit/16-byte bus-based design with configurable data and address widths, synchronous reset, a flags register, and an external program-load port. It sits at the top of the design and is driven only by the board clock and host/testbench load signals.

## Interface
- DATA_W, 8, data/instruction word width; must satisfy DATA_W >= ADDR_W + 4
- ADDR_W, 4, RAM address width; RAM depth = 2**ADDR_W words of DATA_W bits
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- prog_we  input  1  program-load write strobe
- prog_addr  input  ADDR_W  program-load address
- prog_data  input  DATA_W  program-load data
- out_data  output  DATA_W  output (display) register
- out_valid  output  1  one-cycle pulse: out_data just updated by OUT
- halted  output  1  core stopped by HLT
- pc  output  ADDR_W  program counter
- carry  output  1  carry flag
- zero  output  1  zero flag

## Operation
- Instruction word: opcode = IR[DATA_W-1:DATA_W-4]; operand = IR[ADDR_W-1:0] (address) or IR[DATA_W-5:0] zero-extended (LDI immediate).
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; 9–D execute as NOP.
- Step counter T0..T4; every instruction takes exactly 5 cycles (no early termination), except HLT, which freezes.
- T0: MAR <= PC. T1: IR <= RAM[MAR]; PC <= PC+1 (wraps mod 2**ADDR_W).
- LDA: T2 MAR <= operand; T3 A <= RAM[MAR].
- ADD/SUB: T2 MAR <= operand; T3 B <= RAM[MAR]; T4 A <= A+B or A+~B+1 (mod 2**DATA_W); carry <= carry-out bit DATA_W (SUB: 1 = no borrow); zero <= (result == 0).
- STA: T2 MAR <= operand; T3 RAM[MAR] <= A.
- LDI: T2 A <= immediate.
- JMP: T2 PC <= operand. JC/JZ: T2 PC <= operand iff carry/zero = 1, else PC unchanged.
- OUT: T2 out_data <= A; out_valid <= 1 for exactly that following cycle.
- HLT: T2 halted <= 1; all state frozen thereafter; only rst exits.
- Flags change only on ADD/SUB T4; all other instructions preserve them.
- RAM: synchronous write, combinational read. Write port muxed: prog_we has priority, honoured only while rst=1 or halted=1; ignored while running.
- Simultaneous prog_we and STA cannot occur (STA only while running).

## Timing
- Reset (rst=1 at edge): PC, A, B, IR, MAR, carry, zero, out_data = 0; out_valid = 0; halted = 0; step = T0. RAM contents preserved.
- rst mid-instruction: aborts immediately; next instruction fetched from address 0.
- First edge after rst deasserts executes T0 of instruction at address 0. Instruction k (straight-line) occupies edges 5k+1..5k+5.
- Register/flag updates visible in the cycle after the executing edge.
- out_valid: high during the cycle after the OUT T2 edge only; never two consecutive cycles.
- halted: high from the cycle after HLT T2 edge; pc then holds HLT address + 1.
- Loaded word visible to fetch at the cycle after the prog_we edge.

## Test plan
- Load during rst: 0:0x1E (LDA 14), 1:0x2F (ADD 15), 2:0xE0, 3:0xF0, 14:28, 15:14; release rst -> out_valid pulse after edge 13 with out_data=42; halted=1 after edge 18; pc=4; carry=0, zero=0.
- Wrap/carry: A=200 via LDA, ADD word 100 -> A=44, carry=1, zero=0; SUB of equal values (LDA x, SUB x, x=7) -> A=0, carry=1, zero=1.
- Conditional jumps: LDI 0, SUB word 1 (A=255, carry=0), JC 9 -> not taken, pc continues; JZ after zero=1 -> pc = target; JMP 15 at top -> executes 15 then wraps to 0.
- STA/LDA round trip: LDI 9, STA 13, LDI 0, LDA 13, OUT -> out_data=9; RAM[13]=9.
- Reset mid-instruction: assert rst at T3 of ADD -> A, flags, pc all 0, no out_valid; next fetch from 0. prog_we while running -> RAM unchanged.
- Halt behaviour: after HLT, 20 clocks -> pc, A, out_data stable, out_valid=0; prog_we now writes RAM; rst then re-runs new program.

Source files
------------

// File: rtl/eater_core_if.sv
// Host-facing bundle of eater_core: program-load port in, display/status out.
interface eater_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic [ADDR_W-1:0] pc;
  logic              carry;
  logic              zero;

  modport master (
    output prog_we, prog_addr, prog_data,
    input  out_data, out_valid, halted, pc, carry, zero
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    output out_data, out_valid, halted, pc, carry, zero
  );
endinterface

// File: rtl/eater_core.sv
// Microcoded accumulator CPU: 5-step fetch/execute over internal RAM, with
// A/B registers, add/sub with carry/zero flags, jumps, OUT and HLT.
module eater_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  eater_core_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

  step_t             r_step, w_step_nxt;
  logic [DATA_W-1:0] r_a, r_b, r_ir, r_out;
  logic [ADDR_W-1:0] r_pc, r_mar;
  logic              r_carry, r_zero, r_halted, r_out_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_operand;
  logic [DATA_W-1:0] w_imm, w_ram_rd, w_alu_b;
  logic [DATA_W:0]   w_sum;
  logic              w_sub, w_jump, w_prog_wr, w_sta_wr;

  assign w_op      = r_ir[DATA_W-1 -: 4];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_imm     = {4'b0000, r_ir[DATA_W-5:0]};
  assign w_ram_rd  = r_mem[r_mar];

  // SUB is A + ~B + 1, so bit DATA_W of the sum is the no-borrow flag.
  assign w_sub   = (w_op == OP_SUB);
  assign w_alu_b = w_sub ? ~r_b : r_b;
  assign w_sum   = {1'b0, r_a} + {1'b0, w_alu_b} + {{DATA_W{1'b0}}, w_sub};

  assign w_jump = (w_op == OP_JMP) ||
                  ((w_op == OP_JC) && r_carry) ||
                  ((w_op == OP_JZ) && r_zero);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_step_nxt = r_step;
    if (!r_halted) begin
      unique case (r_step)
        T0:      w_step_nxt = T1;
        T1:      w_step_nxt = T2;
        T2:      w_step_nxt = (w_op == OP_HLT) ? T2 : T3;
        T3:      w_step_nxt = T4;
        T4:      w_step_nxt = T0;
        default: w_step_nxt = T0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_step <= T0;
    else     r_step <= w_step_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (!r_halted) begin
        unique case (r_step)
          T0: r_mar <= r_pc;
          T1: begin
            r_ir <= w_ram_rd;
            r_pc <= r_pc + PC_ONE;
          end
          T2: begin
            if (w_op == OP_LDA || w_op == OP_ADD || w_op == OP_SUB || w_op == OP_STA)
              r_mar <= w_operand;
            if (w_op == OP_LDI) r_a <= w_imm;
            if (w_jump)         r_pc <= w_operand;
            if (w_op == OP_OUT) begin
              r_out       <= r_a;
              r_out_valid <= 1'b1;
            end
            if (w_op == OP_HLT) r_halted <= 1'b1;
          end
          T3: begin
            if (w_op == OP_LDA)                    r_a <= w_ram_rd;
            if (w_op == OP_ADD || w_op == OP_SUB)  r_b <= w_ram_rd;
          end
          T4: begin
            if (w_op == OP_ADD || w_op == OP_SUB) begin
              r_a     <= w_sum[DATA_W-1:0];
              r_carry <= w_sum[DATA_W];
              r_zero  <= (w_sum[DATA_W-1:0] == '0);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Host loads win, but only while the core is held in reset or stopped.
  assign w_prog_wr = bus.prog_we && (rst || r_halted);
  assign w_sta_wr  = !rst && !r_halted && (r_step == T3) && (w_op == OP_STA);

  // NOTE: the RAM has no reset so programs survive rst; it maps onto plain
  // memory cells instead of a register file with clear logic.
  always_ff @(posedge clk) begin
    if (w_prog_wr)     r_mem[bus.prog_addr] <= bus.prog_data;
    else if (w_sta_wr) r_mem[r_mar]         <= r_a;
  end

  assign bus.out_data  = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.halted    = r_halted;
  assign bus.pc        = r_pc;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_eater_core.sv
// Scoreboard bench for eater_core: an instruction-level model predicts OUT and
// HLT events (edge number and values); a monitor matches them as they appear.
module tb_eater_core;
  logic clk = 1'b0;
  logic rst = 1'b1;

  eater_core_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  eater_core #(.DATA_W(8), .ADDR_W(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit         is_halt;
    int         edge_n;
    logic [7:0] data;
    logic [3:0] pc;
    bit         c;
    bit         z;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [16];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         m_halted;
  int         halt_edge, m_pc, m_out, m_c, m_z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Edges counted from reset release: the first running edge is edge 1.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin : monitor
    bit   prev_h = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0 || exp_q[0].is_halt) begin
            n_checks++; n_fail++;
            $display("FAIL out_unexpected: out_valid at edge %0d data %0h, none expected", cyc, bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_edge", cyc, e.edge_n);
            check("out_data", bus.out_data, e.data);
          end
        end
        if (bus.halted && !prev_h) begin
          if (exp_q.size() == 0 || !exp_q[0].is_halt) begin
            n_checks++; n_fail++;
            $display("FAIL halt_unexpected: halted at edge %0d, none expected", cyc);
          end else begin
            e = exp_q.pop_front();
            check("halt_edge", cyc, e.edge_n);
            check("halt_pc", bus.pc, e.pc);
            check("halt_carry", bus.carry, e.c);
            check("halt_zero", bus.zero, e.z);
          end
        end
      end
      prev_h = bus.halted;
    end
  end

  // Instruction-level model: instruction k has T2 at edge 5k+3, T3 at 5k+4,
  // T4 at 5k+5; only edges up to run_edges take effect before reset.
  task automatic model_run(input int run_edges);
    int pc = 0, a = 0, c = 0, z = 0, k = 0, op, opd, b, s;
    logic [7:0] ir;
    exp_t e;
    m_halted = 1'b0;
    m_out    = 0;
    forever begin
      if (5 * k + 3 > run_edges) break;
      ir  = mem_m[pc];
      pc  = (pc + 1) % 16;
      op  = int'(ir[7:4]);
      opd = int'(ir[3:0]);
      case (op)
        1: if (5 * k + 4 <= run_edges) a = mem_m[opd];
        2: if (5 * k + 5 <= run_edges) begin
             s = a + mem_m[opd];
             c = (s > 255) ? 1 : 0;
             a = s % 256;
             z = (a == 0) ? 1 : 0;
           end
        3: if (5 * k + 5 <= run_edges) begin
             b = mem_m[opd];
             c = (a >= b) ? 1 : 0;
             a = (a - b + 256) % 256;
             z = (a == 0) ? 1 : 0;
           end
        4: if (5 * k + 4 <= run_edges) mem_m[opd] = 8'(a);
        5: a = opd;
        6: pc = opd;
        7: if (c != 0) pc = opd;
        8: if (z != 0) pc = opd;
        14: begin
          m_out = a;
          e = '{is_halt: 1'b0, edge_n: 5 * k + 3, data: 8'(a), pc: 4'(0), c: 1'b0, z: 1'b0};
          exp_q.push_back(e);
        end
        15: begin
          e = '{is_halt: 1'b1, edge_n: 5 * k + 3, data: 8'(0), pc: 4'(pc), c: c[0], z: z[0]};
          exp_q.push_back(e);
          m_halted  = 1'b1;
          halt_edge = 5 * k + 3;
        end
        default: ;
      endcase
      if (m_halted) break;
      k++;
    end
    m_pc = pc; m_c = c; m_z = z;
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data, input bit takes_effect);
    bus.prog_addr = addr;
    bus.prog_data = data;
    bus.prog_we   = 1'b1;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    if (takes_effect) mem_m[addr] = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Called with rst=1; releases reset and runs; we_at >= 0 pulses an ignored
  // prog_we (address/data preset by the caller) before that running edge.
  task automatic run(input int run_edges, input int we_at, input bit stab);
    int limit;
    @(negedge clk);
    check("rst_pc", bus.pc, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_zero", bus.zero, 0);
    model_run(run_edges);
    limit = m_halted ? halt_edge + 2 : run_edges;
    rst = 1'b0;
    for (int i = 0; i < limit; i++) begin
      bus.prog_we = (i == we_at);
      @(negedge clk);
    end
    bus.prog_we = 1'b0;
    check("events_drained", exp_q.size(), 0);
    exp_q.delete();
    if (stab && m_halted) begin
      for (int i = 0; i < 20; i++) begin
        check("hold_pc", bus.pc, m_pc);
        check("hold_out_data", bus.out_data, m_out);
        check("hold_out_valid", bus.out_valid, 0);
        check("hold_halted", bus.halted, 1);
        @(negedge clk);
      end
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE, 4'hF};
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) load(4'(i), 8'h00, 1'b1);

    // Test-plan program: 28 + 14 -> OUT 42 at edge 13, HLT at edge 18, pc 4.
    load(0, 8'h1E, 1); load(1, 8'h2F, 1); load(2, 8'hE0, 1); load(3, 8'hF0, 1);
    load(14, 8'd28, 1); load(15, 8'd14, 1);
    run(100, -1, 0); do_reset();

    // 200 + 100 wraps to 44 with carry.
    load(14, 8'd200, 1); load(15, 8'd100, 1);
    run(100, -1, 0); do_reset();

    // 7 - 7: zero result, no borrow.
    load(1, 8'h3E, 1); load(14, 8'd7, 1);
    run(100, -1, 0); do_reset();

    // LDI 0; SUB 1 -> 255 with borrow; JC not taken.
    load(0, 8'h50, 1); load(1, 8'h3F, 1); load(2, 8'h79, 1); load(3, 8'hE0, 1);
    load(4, 8'hF0, 1); load(9, 8'hF0, 1); load(15, 8'd1, 1);
    run(100, -1, 0); do_reset();

    // Zero set, JZ 6 taken.
    load(0, 8'h1E, 1); load(1, 8'h3E, 1); load(2, 8'h86, 1); load(3, 8'hE0, 1);
    load(4, 8'hF0, 1); load(6, 8'h55, 1); load(7, 8'hE0, 1); load(8, 8'hF0, 1);
    run(100, -1, 0); do_reset();

    // JMP 15; HLT at 15 leaves pc wrapped to 0.
    load(0, 8'h53, 1); load(1, 8'hE0, 1); load(2, 8'h6F, 1); load(15, 8'hF0, 1);
    run(100, -1, 0); do_reset();

    // STA/LDA round trip through address 13.
    load(0, 8'h59, 1); load(1, 8'h4D, 1); load(2, 8'h50, 1); load(3, 8'h1D, 1);
    load(4, 8'hE0, 1); load(5, 8'hF0, 1);
    run(100, -1, 0); do_reset();
    check("ram13_via_model", mem_m[13], 9);

    // Reset lands on T3 of ADD (edge 9); then the same program re-runs from 0.
    load(0, 8'h1E, 1); load(1, 8'h2F, 1); load(2, 8'hE0, 1); load(3, 8'hF0, 1);
    load(14, 8'd28, 1); load(15, 8'd14, 1);
    run(8, -1, 0); do_reset();
    run(100, -1, 0); do_reset();

    // prog_we while running is ignored; then halt hold, load while halted, rerun.
    load(0, 8'h00, 1); load(1, 8'h00, 1); load(2, 8'h1E, 1); load(3, 8'hE0, 1);
    load(4, 8'hF0, 1); load(14, 8'h3C, 1);
    bus.prog_addr = 4'd14; bus.prog_data = 8'h55;
    run(100, 3, 1);
    load(0, 8'h56, 1); load(1, 8'hE0, 1); load(2, 8'hF0, 1);
    do_reset();
    run(100, -1, 1); do_reset();

    // Random programs with random abort points.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] op;
        op = ops[$urandom_range(0, 11)];
        load(4'(i), {op, 4'($urandom_range(0, 15))}, 1'b1);
      end
      run($urandom_range(15, 150), -1, 0); do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
